// File: rtl/ipm_distributed_fifo_v2_0_pkt.sv
// rtl/ipm_distributed_fifo_v2_0_pkt.sv - distributed-RAM FIFO with optional FWFT read and packet commit/abort
module ipm_distributed_fifo_v2_0_pkt #(
   parameter int ADDR_WIDTH       = 10,
   parameter int DATA_WIDTH       = 32,
   parameter int FWFT             = 0,
   parameter int PKT_MODE         = 0,
   parameter int ALMOST_FULL_NUM  = 4,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   input  logic                  wr_commit,
   input  logic                  wr_abort,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_water_level,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_en,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_water_level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam int AF_INT = DEPTH - ALMOST_FULL_NUM;
   localparam logic [ADDR_WIDTH:0] DEPTH_LVL = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AF_LVL    = AF_INT[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_LVL    = ALMOST_EMPTY_NUM[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   cm_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   wr_ptr_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_water_level = wr_ptr - rd_ptr;
   assign rd_water_level = cm_ptr - rd_ptr;
   assign full           = (wr_water_level == DEPTH_LVL);
   assign empty          = (rd_water_level == '0);
   assign almost_full    = (wr_water_level >= AF_LVL);
   assign almost_empty   = (rd_water_level <= AE_LVL);

   assign wr_acc     = wr_en & ~full;
   assign rd_acc     = rd_en & ~empty;
   assign wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};

   // RAM array is intentionally left unreset so it maps onto distributed RAM
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         cm_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (PKT_MODE == 0) begin
            wr_ptr <= wr_ptr_nxt;
            cm_ptr <= wr_ptr_nxt;
         end else if (wr_abort) begin
            // abort beats commit and drops this cycle's write
            wr_ptr <= cm_ptr;
         end else begin
            wr_ptr <= wr_ptr_nxt;
            if (wr_commit) begin
               cm_ptr <= wr_ptr_nxt;
            end
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rd_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_q <= '0;
            end else if (rd_acc) begin
               rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
         end
         assign rd_data = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_ipm_distributed_fifo_v2_0_pkt.sv
// tb/tb_ipm_distributed_fifo_v2_0_pkt.sv - directed bench: plain/standard instance and packet/FWFT instance
module tb_ipm_distributed_fifo_v2_0_pkt;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // instance a: PKT_MODE=0, FWFT=0
   logic [7:0] a_wr_data = '0;
   logic       a_wr_en = 1'b0, a_rd_en = 1'b0;
   logic       a_full, a_almost_full, a_empty, a_almost_empty, a_overflow, a_underflow;
   logic [4:0] a_wr_lvl, a_rd_lvl;
   logic [7:0] a_rd_data;

   // instance b: PKT_MODE=1, FWFT=1
   logic [7:0] b_wr_data = '0;
   logic       b_wr_en = 1'b0, b_rd_en = 1'b0, b_commit = 1'b0, b_abort = 1'b0;
   logic       b_full, b_almost_full, b_empty, b_almost_empty, b_overflow, b_underflow;
   logic [4:0] b_wr_lvl, b_rd_lvl;
   logic [7:0] b_rd_data;

   ipm_distributed_fifo_v2_0_pkt #(
      .ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0), .PKT_MODE(0),
      .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)
   ) dut_a (
      .clk(clk), .rst(rst), .wr_data(a_wr_data), .wr_en(a_wr_en),
      .wr_commit(1'b0), .wr_abort(1'b0), .full(a_full), .almost_full(a_almost_full),
      .wr_water_level(a_wr_lvl), .rd_data(a_rd_data), .rd_en(a_rd_en), .empty(a_empty),
      .almost_empty(a_almost_empty), .rd_water_level(a_rd_lvl),
      .overflow(a_overflow), .underflow(a_underflow)
   );

   ipm_distributed_fifo_v2_0_pkt #(
      .ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1), .PKT_MODE(1),
      .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)
   ) dut_b (
      .clk(clk), .rst(rst), .wr_data(b_wr_data), .wr_en(b_wr_en),
      .wr_commit(b_commit), .wr_abort(b_abort), .full(b_full), .almost_full(b_almost_full),
      .wr_water_level(b_wr_lvl), .rd_data(b_rd_data), .rd_en(b_rd_en), .empty(b_empty),
      .almost_empty(b_almost_empty), .rd_water_level(b_rd_lvl),
      .overflow(b_overflow), .underflow(b_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_a();
      chk("a_rst_empty", a_empty, 1);
      chk("a_rst_aempty", a_almost_empty, 1);
      chk("a_rst_full", a_full, 0);
      chk("a_rst_afull", a_almost_full, 0);
      chk("a_rst_wlvl", a_wr_lvl, 0);
      chk("a_rst_rlvl", a_rd_lvl, 0);
      chk("a_rst_ovf", a_overflow, 0);
      chk("a_rst_udf", a_underflow, 0);
      chk("a_rst_rdata", a_rd_data, 0);
   endtask

   task automatic chk_reset_b();
      chk("b_rst_empty", b_empty, 1);
      chk("b_rst_aempty", b_almost_empty, 1);
      chk("b_rst_full", b_full, 0);
      chk("b_rst_afull", b_almost_full, 0);
      chk("b_rst_wlvl", b_wr_lvl, 0);
      chk("b_rst_rlvl", b_rd_lvl, 0);
      chk("b_rst_ovf", b_overflow, 0);
      chk("b_rst_udf", b_underflow, 0);
   endtask

   initial begin
      cycle();
      cycle();
      chk_reset_a();
      chk_reset_b();
      rst = 1'b0;
      cycle();

      // ---------------- instance a: fill, overflow, drain ----------------
      for (int i = 1; i <= 16; i++) begin
         a_wr_en = 1'b1;
         a_wr_data = 8'(i);
         cycle();
         if (i == 12) chk("a_afull_at12", a_almost_full, 1);
         if (i == 11) chk("a_afull_at11", a_almost_full, 0);
      end
      a_wr_en = 1'b0;
      chk("a_full16", a_full, 1);
      chk("a_wlvl16", a_wr_lvl, 16);
      chk("a_rlvl16", a_rd_lvl, 16);
      chk("a_empty16", a_empty, 0);

      a_wr_en = 1'b1;
      a_wr_data = 8'h11;
      cycle();
      a_wr_en = 1'b0;
      chk("a_ovf", a_overflow, 1);
      chk("a_wlvl_after_ovf", a_wr_lvl, 16);

      for (int i = 1; i <= 16; i++) begin
         a_rd_en = 1'b1;
         cycle();
         chk("a_rd_data", a_rd_data, 32'(i));
         chk("a_rd_lvl", a_rd_lvl, 32'(16 - i));
         if (i == 11) chk("a_aempty_lvl5", a_almost_empty, 0);
         if (i == 12) chk("a_aempty_lvl4", a_almost_empty, 1);
      end
      a_rd_en = 1'b0;
      chk("a_empty_drained", a_empty, 1);
      chk("a_udf_clear", a_underflow, 0);

      a_rd_en = 1'b1;
      cycle();
      a_rd_en = 1'b0;
      chk("a_udf", a_underflow, 1);
      chk("a_rdata_hold", a_rd_data, 8'h10);

      // simultaneous read+write while empty: only the write happens
      a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'h55;
      cycle();
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      chk("a_sim_empty_lvl", a_wr_lvl, 1);
      chk("a_sim_empty_rlvl", a_rd_lvl, 1);
      chk("a_sim_empty_rdata", a_rd_data, 8'h10);

      for (int i = 0; i < 15; i++) begin
         a_wr_en = 1'b1;
         a_wr_data = 8'(8'h56 + i);
         cycle();
      end
      a_wr_en = 1'b0;
      chk("a_refull", a_full, 1);

      // simultaneous read+write while full: only the read happens
      a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'hEE;
      cycle();
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      chk("a_sim_full_lvl", a_wr_lvl, 15);
      chk("a_sim_full_rdata", a_rd_data, 8'h55);
      chk("a_sim_full_full", a_full, 0);

      // ---------------- instance b: packet mode + FWFT ----------------
      for (int i = 0; i < 5; i++) begin
         b_wr_en = 1'b1;
         b_wr_data = 8'(8'hA0 + i);
         cycle();
      end
      b_wr_en = 1'b0;
      chk("b_pend_empty", b_empty, 1);
      chk("b_pend_wlvl", b_wr_lvl, 5);
      chk("b_pend_rlvl", b_rd_lvl, 0);

      b_wr_en = 1'b1; b_wr_data = 8'hA5; b_commit = 1'b1;
      cycle();
      b_wr_en = 1'b0; b_commit = 1'b0;
      chk("b_cm_empty", b_empty, 0);
      chk("b_cm_rdata", b_rd_data, 8'hA0);
      chk("b_cm_rlvl", b_rd_lvl, 6);

      for (int i = 0; i < 6; i++) begin
         chk("b_fwft_data", b_rd_data, 32'(8'hA0 + i));
         b_rd_en = 1'b1;
         cycle();
         b_rd_en = 1'b0;
      end
      chk("b_drained", b_empty, 1);

      // commit 3, write 4 more, abort with a write
      for (int i = 0; i < 3; i++) begin
         b_wr_en = 1'b1; b_wr_data = 8'(8'hB0 + i); b_commit = (i == 2);
         cycle();
      end
      b_commit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         b_wr_en = 1'b1; b_wr_data = 8'(8'hC0 + i);
         cycle();
      end
      chk("b_pre_abort_wlvl", b_wr_lvl, 7);
      b_wr_en = 1'b1; b_wr_data = 8'hCC; b_abort = 1'b1;
      cycle();
      b_wr_en = 1'b0; b_abort = 1'b0;
      chk("b_abort_wlvl", b_wr_lvl, 3);
      chk("b_abort_rlvl", b_rd_lvl, 3);
      for (int i = 0; i < 3; i++) begin
         chk("b_pkt_data", b_rd_data, 32'(8'hB0 + i));
         b_rd_en = 1'b1;
         cycle();
         b_rd_en = 1'b0;
      end
      chk("b_pkt_empty", b_empty, 1);
      chk("b_pkt_wlvl0", b_wr_lvl, 0);

      // commit and abort together: abort wins
      for (int i = 0; i < 2; i++) begin
         b_wr_en = 1'b1; b_wr_data = 8'(8'hD0 + i);
         cycle();
      end
      b_wr_en = 1'b1; b_wr_data = 8'hD2; b_commit = 1'b1; b_abort = 1'b1;
      cycle();
      b_wr_en = 1'b0; b_commit = 1'b0; b_abort = 1'b0;
      chk("b_both_wlvl", b_wr_lvl, 0);
      chk("b_both_empty", b_empty, 1);
      chk("b_udf_clear", b_underflow, 0);

      // 7 committed + 2 pending, then asynchronous reset mid-packet
      for (int i = 0; i < 7; i++) begin
         b_wr_en = 1'b1; b_wr_data = 8'(8'hE0 + i); b_commit = (i == 6);
         cycle();
      end
      b_commit = 1'b0;
      for (int i = 0; i < 2; i++) begin
         b_wr_en = 1'b1; b_wr_data = 8'(8'hF0 + i);
         cycle();
      end
      b_wr_en = 1'b0;
      chk("b_pre_rst_rlvl", b_rd_lvl, 7);
      chk("b_pre_rst_wlvl", b_wr_lvl, 9);
      #1 rst = 1'b1;
      #1;
      chk_reset_b();
      chk_reset_a();
      cycle();
      rst = 1'b0;
      b_wr_en = 1'b1; b_wr_data = 8'h3C; b_commit = 1'b1;
      cycle();
      b_wr_en = 1'b0; b_commit = 1'b0;
      chk("b_post_rst_empty", b_empty, 0);
      chk("b_post_rst_rdata", b_rd_data, 8'h3C);
      chk("b_post_rst_rlvl", b_rd_lvl, 1);
      b_rd_en = 1'b1;
      cycle();
      b_rd_en = 1'b0;
      chk("b_post_rst_pop", b_empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
